// File: rtl/uart_rx_os.sv
// 16x oversampled UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_os #(
  parameter int Bits    = 8,
  parameter int OS_TICK = 16,
  parameter int SB_TICK = 16
) (
  input  logic            i_Clock,
  input  logic            i_reset,
  input  logic            i_bd,
  input  logic            i_Rx_Serial,
  output logic [Bits-1:0] o_Rx_Byte,
  output logic            o_Rx_Done,
  output logic            o_Rx_Active,
  output logic            o_Frame_Err,
  output logic            o_Parity_Err
);

  localparam int TMAX = (OS_TICK > SB_TICK) ?
                        OS_TICK : SB_TICK;
  localparam int CW = $clog2(TMAX);
  localparam int IW = (Bits > 1) ? $clog2(Bits) : 1;

  localparam logic [CW-1:0] MID    = CW'(OS_TICK/2 - 1);
  localparam logic [CW-1:0] END_OS = CW'(OS_TICK - 1);
  localparam logic [CW-1:0] END_SB = CW'(SB_TICK - 1);
  localparam logic [IW-1:0] LAST   = IW'(Bits - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [Bits-1:0] sh;
  logic            rx_q;
  logic            rx_s;

  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_q <= i_Rx_Serial;
      rx_s <= rx_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par;
`else
  assign o_Parity_Err = 1'b0;
`endif

  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      o_Rx_Byte   <= '0;
      o_Rx_Done   <= 1'b0;
      o_Rx_Active <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par          <= 1'b0;
      o_Parity_Err <= 1'b0;
`endif
    end else begin
      o_Rx_Done   <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Parity_Err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state       <= START;
            cnt         <= '0;
            o_Rx_Active <= 1'b1;
          end
        end
        START: begin
          if (i_bd) begin
            if (cnt == MID) begin
              cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
                idx   <= '0;
              end else begin
                state       <= IDLE;
                o_Rx_Active <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_bd) begin
            if (cnt == END_OS) begin
              cnt <= '0;
              sh  <= {rx_s, sh[Bits-1:1]};
              if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_bd) begin
            if (cnt == END_OS) begin
              cnt   <= '0;
              par   <= rx_s;
              state <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (i_bd) begin
            if (cnt == END_SB) begin
              cnt <= '0;
              if (rx_s) begin
                state       <= IDLE;
                o_Rx_Active <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (par ^ (^sh)) begin
                  o_Parity_Err <= 1'b1;
                end else begin
                  o_Rx_Byte <= sh;
                  o_Rx_Done <= 1'b1;
                end
`else
                o_Rx_Byte <= sh;
                o_Rx_Done <= 1'b1;
`endif
              end else begin
                // Line stuck low: report once, wait out the break
                o_Frame_Err <= 1'b1;
                state       <= BREAK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state       <= IDLE;
            o_Rx_Active <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os.
// i_bd ticks every 10 clocks, so one bit lasts 160 clocks.
module tb_uart_rx_os;

  logic       i_Clock = 1'b0;
  logic       i_reset;
  logic       i_bd;
  logic       i_Rx_Serial;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Done;
  logic       o_Rx_Active;
  logic       o_Frame_Err;
  logic       o_Parity_Err;

  uart_rx_os dut (
    .i_Clock      (i_Clock),
    .i_reset      (i_reset),
    .i_bd         (i_bd),
    .i_Rx_Serial  (i_Rx_Serial),
    .o_Rx_Byte    (o_Rx_Byte),
    .o_Rx_Done    (o_Rx_Done),
    .o_Rx_Active  (o_Rx_Active),
    .o_Frame_Err  (o_Frame_Err),
    .o_Parity_Err (o_Parity_Err)
  );

  initial forever #5 i_Clock = ~i_Clock;

  localparam int BIT = 160;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_bad = 0;
  int t_done = 0;
  int t_stop = 0;
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] rxq[$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic stop);
    i_Rx_Serial = 1'b0;
    wclk(BIT);
    for (int i = 0; i < 8; i++) begin
      i_Rx_Serial = d[i];
      wclk(BIT);
    end
`ifdef UART_RX_PARITY_EN
    i_Rx_Serial = (^d) ^ par_flip;
    wclk(BIT);
`endif
    t_stop = cyc;
    i_Rx_Serial = stop;
    wclk(BIT);
    i_Rx_Serial = 1'b1;
  endtask

  initial begin
    int bdc;
    bdc = 0;
    i_bd = 1'b0;
    forever begin
      @(negedge i_Clock);
      bdc = (bdc == 9) ? 0 : bdc + 1;
      i_bd = (bdc == 0);
    end
  end

  always @(negedge i_Clock) begin
    cyc++;
    if (o_Rx_Done) begin
      n_done++;
      t_done = cyc;
      rxq.push_back(o_Rx_Byte);
      if (prev_done) n_bad++;
      if (o_Frame_Err || o_Parity_Err) n_bad++;
    end
    if (o_Frame_Err) begin
      n_ferr++;
      if (prev_ferr) n_bad++;
    end
    if (o_Parity_Err) n_perr++;
    prev_done = o_Rx_Done;
    prev_ferr = o_Frame_Err;
  end

  initial begin
    int t0;
    i_reset = 1'b1;
    i_Rx_Serial = 1'b1;
    wclk(5);
    chk("rst_byte", 32'(o_Rx_Byte), 32'h00);
    chk("rst_done", 32'(o_Rx_Done), 32'h0);
    chk("rst_active", 32'(o_Rx_Active), 32'h0);
    chk("rst_ferr", 32'(o_Frame_Err), 32'h0);
    chk("rst_perr", 32'(o_Parity_Err), 32'h0);
    i_reset = 1'b0;
    wclk(BIT);

    // 1: single byte and strobe latency
    send(8'hA5, 1'b1);
    wclk(BIT);
    chk("t1_ndone", 32'(n_done), 32'd1);
    chk("t1_byte", 32'(o_Rx_Byte), 32'hA5);
    chk("t1_ferr", 32'(n_ferr), 32'd0);
    chk("t1_lat_ok",
        32'((t_done - t_stop >= 70) &&
            (t_done - t_stop <= 95)), 32'd1);

    // 2: back-to-back frames, no idle gap
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h3C, 1'b1);
    wclk(2*BIT);
    chk("t2_ndone", 32'(n_done), 32'd4);
    chk("t2_q1", 32'(rxq[1]), 32'h00);
    chk("t2_q2", 32'(rxq[2]), 32'hFF);
    chk("t2_q3", 32'(rxq[3]), 32'h3C);

    // 3: 4-tick glitch on the idle line
    i_Rx_Serial = 1'b0;
    wclk(20);
    chk("t3_act_hi", 32'(o_Rx_Active), 32'd1);
    wclk(20);
    i_Rx_Serial = 1'b1;
    wclk(52);
    chk("t3_act_lo", 32'(o_Rx_Active), 32'd0);
    wclk(2*BIT);
    chk("t3_ndone", 32'(n_done), 32'd4);
    chk("t3_ferr", 32'(n_ferr), 32'd0);

    // 4: missing stop bit then break
    send(8'h55, 1'b0);
    i_Rx_Serial = 1'b0;
    wclk(3*BIT);
    chk("t4_act_brk", 32'(o_Rx_Active), 32'd1);
    i_Rx_Serial = 1'b1;
    wclk(2*BIT);
    chk("t4_ferr", 32'(n_ferr), 32'd1);
    chk("t4_byte_hold", 32'(o_Rx_Byte), 32'h3C);
    chk("t4_ndone", 32'(n_done), 32'd4);
    send(8'h12, 1'b1);
    wclk(BIT);
    chk("t4_byte", 32'(o_Rx_Byte), 32'h12);
    chk("t4_ndone2", 32'(n_done), 32'd5);

    // 5: reset in the middle of data bit 4 of 0x81
    i_Rx_Serial = 1'b0;
    wclk(BIT);
    i_Rx_Serial = 1'b1;
    wclk(BIT);
    i_Rx_Serial = 1'b0;
    wclk(3*BIT + BIT/2);
    chk("t5_act_pre", 32'(o_Rx_Active), 32'd1);
    i_reset = 1'b1;
    i_Rx_Serial = 1'b1;
    wclk(2);
    chk("t5_byte", 32'(o_Rx_Byte), 32'h00);
    chk("t5_active", 32'(o_Rx_Active), 32'd0);
    chk("t5_done", 32'(o_Rx_Done), 32'd0);
    chk("t5_ferr", 32'(o_Frame_Err), 32'd0);
    i_reset = 1'b0;
    wclk(2*BIT);
    send(8'h81, 1'b1);
    wclk(BIT);
    chk("t5_byte2", 32'(o_Rx_Byte), 32'h81);
    chk("t5_ndone", 32'(n_done), 32'd6);

`ifdef UART_RX_PARITY_EN
    // 6: parity error then good parity
    par_flip = 1'b1;
    send(8'h07, 1'b1);
    wclk(BIT);
    chk("t6_perr", 32'(n_perr), 32'd1);
    chk("t6_ndone", 32'(n_done), 32'd6);
    chk("t6_hold", 32'(o_Rx_Byte), 32'h81);
    par_flip = 1'b0;
    send(8'h07, 1'b1);
    wclk(BIT);
    chk("t6_byte", 32'(o_Rx_Byte), 32'h07);
    chk("t6_ndone2", 32'(n_done), 32'd7);
    chk("t6_perr2", 32'(n_perr), 32'd1);
`else
    chk("perr_none", 32'(n_perr), 32'd0);
`endif

    t0 = n_ferr;
    chk("fin_ferr", 32'(t0), 32'd1);
    chk("fin_bad", 32'(n_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
